// File: rtl/alu_arbiter_if.sv
// Request/response and shared-ALU signal bundle for alu_arbiter.
// slave = arbiter side, master = requesters plus the external ALU.
interface alu_arbiter_if #(
  parameter int W   = 6,
  parameter int OPW = 2
);
  logic           req0, req1;
  logic [W-1:0]   a0, b0, a1, b1;
  logic [OPW-1:0] op0, op1;
  logic           ack0, ack1, done0, done1;
  logic [W-1:0]   result0, result1;
  logic           flag0, flag1;
  logic [W-1:0]   alu_in1, alu_in2;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_out;
  logic           alu_flag;
  logic           busy;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1, alu_out, alu_flag,
    output ack0, ack1, done0, done1, result0, result1, flag0, flag1,
           alu_in1, alu_in2, alu_op, busy
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1, alu_out, alu_flag,
    input  ack0, ack1, done0, done1, result0, result1, flag0, flag1,
           alu_in1, alu_in2, alu_op, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation every 3 cycles: IDLE (grant) -> EXEC (ack, drive ALU) -> RESP (done).
module alu_arbiter #(
  parameter int W   = 6,
  parameter int OPW = 2
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e               state_q;
  logic                 win_q, last_q;
  logic [1:0]           ack_q, done_q;
  logic [1:0][W-1:0]    res_q;
  logic [1:0]           flag_q;
  logic [W-1:0]         alu_in1_q, alu_in2_q;
  logic [OPW-1:0]       alu_op_q;

  logic [1:0]           req;
  logic [1:0][W-1:0]    a, b;
  logic [1:0][OPW-1:0]  op;
  logic                 gnt;

  assign req = {bus.req1, bus.req0};
  assign a   = {bus.a1, bus.a0};
  assign b   = {bus.b1, bus.b0};
  assign op  = {bus.op1, bus.op0};

  // Requester 1 wins when alone, or on a tie when requester 0 had the last grant.
  assign gnt = req[1] & (~req[0] | ~last_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      ack_q     <= '0;
      done_q    <= '0;
      res_q     <= '0;
      flag_q    <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      alu_op_q  <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            win_q      <= gnt;
            last_q     <= gnt;
            alu_in1_q  <= a[gnt];
            alu_in2_q  <= b[gnt];
            alu_op_q   <= op[gnt];
            ack_q[gnt] <= 1'b1;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          res_q[win_q]  <= bus.alu_out;
          flag_q[win_q] <= bus.alu_flag;
          done_q[win_q] <= 1'b1;
          alu_in1_q     <= '0;
          alu_in2_q     <= '0;
          alu_op_q      <= '0;
          state_q       <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack0    = ack_q[0];
  assign bus.ack1    = ack_q[1];
  assign bus.done0   = done_q[0];
  assign bus.done1   = done_q[1];
  assign bus.result0 = res_q[0];
  assign bus.result1 = res_q[1];
  assign bus.flag0   = flag_q[0];
  assign bus.flag1   = flag_q[1];
  assign bus.alu_in1 = alu_in1_q;
  assign bus.alu_in2 = alu_in2_q;
  assign bus.alu_op  = alu_op_q;
  assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, hand-written corner sequences and a
// randomized run against a cycle-count/queue level reference model.
module tb_alu_arbiter;
  localparam int W   = 6;
  localparam int OPW = 2;
  localparam int AW  = 2 * W + OPW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.W(W), .OPW(OPW)) bus();
  alu_arbiter #(.W(W), .OPW(OPW)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  // External ALU: add(carry), sub(borrow), and(zero), xor(zero); returns {flag,result}.
  function automatic logic [W:0] alu_fn(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [OPW-1:0] o);
    logic [W:0] s;
    s = '0;
    case (o)
      2'd0: s = {1'b0, x} + {1'b0, y};
      2'd1: begin s[W-1:0] = x - y; s[W] = (x < y); end
      2'd2: begin s[W-1:0] = x & y; s[W] = ((x & y) == '0); end
      default: begin s[W-1:0] = x ^ y; s[W] = ((x ^ y) == '0); end
    endcase
    return s;
  endfunction

  assign {bus.alu_flag, bus.alu_out} = alu_fn(bus.alu_in1, bus.alu_in2, bus.alu_op);

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_res[2];
  logic         exp_flag[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ack_of(input bit who);
    return who ? bus.ack1 : bus.ack0;
  endfunction
  function automatic logic done_of(input bit who);
    return who ? bus.done1 : bus.done0;
  endfunction
  function automatic logic [W:0] res_of(input bit who);
    return who ? {bus.flag1, bus.result1} : {bus.flag0, bus.result0};
  endfunction

  task automatic drive_req(input bit who, input logic r, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [OPW-1:0] o);
    if (who) begin bus.req1 = r; bus.a1 = x; bus.b1 = y; bus.op1 = o; end
    else     begin bus.req0 = r; bus.a0 = x; bus.b0 = y; bus.op0 = o; end
  endtask

  task automatic scramble(input bit who);
    drive_req(who, 1'b0, W'($urandom), W'($urandom), OPW'($urandom));
  endtask

  task automatic chk_zero(input string name);
    chk(name, {bus.ack0, bus.ack1, bus.done0, bus.done1, bus.busy, bus.flag0, bus.flag1,
               bus.result0, bus.result1, bus.alu_in1, bus.alu_in2, bus.alu_op}, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, '0, '0, '0);
    drive_req(1'b1, 1'b0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_res  = '{default: '0};
    exp_flag = '{default: 1'b0};
  endtask

  typedef struct {
    bit             who;
    logic [W-1:0]   a, b;
    logic [OPW-1:0] op;
    logic [W-1:0]   r;
    logic           f;
  } vec_t;

  task automatic single_op(input vec_t v);
    @(negedge clk);
    drive_req(v.who, 1'b1, v.a, v.b, v.op);
    @(negedge clk);
    chk("vec_ack", ack_of(v.who), 1'b1);
    chk("vec_ack_other", ack_of(!v.who), 1'b0);
    chk("vec_alu_drive", {bus.alu_in1, bus.alu_in2, bus.alu_op}, {v.a, v.b, v.op});
    scramble(v.who);
    @(negedge clk);
    chk("vec_done", done_of(v.who), 1'b1);
    chk("vec_result", res_of(v.who), {v.f, v.r});
    chk("vec_other_hold", res_of(!v.who), {exp_flag[!v.who], exp_res[!v.who]});
    chk("vec_alu_zero_resp", {bus.alu_in1, bus.alu_in2, bus.alu_op}, '0);
    exp_res[v.who]  = v.r;
    exp_flag[v.who] = v.f;
    @(negedge clk);
    chk("vec_idle", {bus.busy, bus.done0, bus.done1, bus.ack0, bus.ack1}, '0);
    chk("vec_result_held", res_of(v.who), {v.f, v.r});
  endtask

  task automatic contend(input bit first);
    logic [W-1:0]   ca[2], cb[2];
    logic [OPW-1:0] co[2];
    int             ac[2], dc[2];
    logic [W:0]     r;
    for (int i = 0; i < 2; i++) begin
      ca[i] = W'($urandom); cb[i] = W'($urandom); co[i] = OPW'($urandom);
      ac[i] = -1; dc[i] = -1;
    end
    @(negedge clk);
    drive_req(1'b0, 1'b1, ca[0], cb[0], co[0]);
    drive_req(1'b1, 1'b1, ca[1], cb[1], co[1]);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("cont_onehot", 64'($countones({bus.ack0, bus.ack1, bus.done0, bus.done1}) <= 1), 1);
      for (int i = 0; i < 2; i++) begin
        if (ack_of(bit'(i))) begin ac[i] = c; scramble(bit'(i)); end
        if (done_of(bit'(i))) begin
          dc[i] = c;
          r = alu_fn(ca[i], cb[i], co[i]);
          chk("cont_result", res_of(bit'(i)), r);
          exp_res[i] = r[W-1:0]; exp_flag[i] = r[W];
        end
      end
    end
    chk("cont_first_ack",   64'(ac[first]),  1);
    chk("cont_first_done",  64'(dc[first]),  2);
    chk("cont_second_ack",  64'(ac[!first]), 4);
    chk("cont_second_done", 64'(dc[!first]), 5);
  endtask

  // Randomized-run state.
  bit             rq[2];
  logic [W-1:0]   pa[2], pb[2];
  logic [OPW-1:0] po[2];
  int             e_ack, e_done, n_ack, w;
  bit             last_w;
  logic [W-1:0]   ea1, ea2;
  logic [OPW-1:0] eop;
  logic [W:0]     er;
  bit             saw1;
  vec_t           vt[8];

  initial begin
    vt[0] = '{1'b0, 6'd5,  6'd3,  2'd0, 6'd8,  1'b0};
    vt[1] = '{1'b1, 6'd60, 6'd10, 2'd0, 6'd6,  1'b1};
    vt[2] = '{1'b0, 6'd3,  6'd5,  2'd1, 6'd62, 1'b1};
    vt[3] = '{1'b1, 6'd45, 6'd27, 2'd2, 6'd9,  1'b0};
    vt[4] = '{1'b0, 6'd42, 6'd42, 2'd3, 6'd0,  1'b1};
    vt[5] = '{1'b1, 6'd63, 6'd1,  2'd1, 6'd62, 1'b0};
    vt[6] = '{1'b0, 6'd63, 6'd63, 2'd2, 6'd63, 1'b0};
    vt[7] = '{1'b1, 6'd0,  6'd0,  2'd0, 6'd0,  1'b0};

    rst_n = 1'b1;
    drive_req(1'b0, 1'b0, '0, '0, '0);
    drive_req(1'b1, 1'b0, '0, '0, '0);
    #3 rst_n = 1'b0;
    #2 chk_zero("reset_outputs");
    do_reset();

    foreach (vt[i]) single_op(vt[i]);

    do_reset();
    contend(1'b0);
    contend(1'b0);

    // One-cycle req1 pulse while requester 0 is in flight is never sampled in IDLE.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 6'd17, 6'd4, 2'd0);
    @(negedge clk);
    chk("wd_ack0", bus.ack0, 1'b1);
    scramble(1'b0);
    drive_req(1'b1, 1'b1, 6'd9, 6'd9, 2'd0);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 6'd9, 6'd9, 2'd0);
    chk("wd_done0", {bus.done0, bus.flag0, bus.result0}, {2'b10, 6'd21});
    saw1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      saw1 |= bus.ack1 | bus.done1;
    end
    chk("wd_no_ack1_done1", saw1, 1'b0);
    chk("wd_result1_hold", res_of(1'b1), {exp_flag[1], exp_res[1]});

    // Reset dropped during EXEC aborts the operation.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 6'd7, 6'd9, 2'd0);
    @(negedge clk);
    chk("rst_mid_ack0", bus.ack0, 1'b1);
    rst_n = 1'b0;
    #1 chk_zero("rst_mid_zero");
    drive_req(1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_res  = '{default: '0};
    exp_flag = '{default: 1'b0};
    saw1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      saw1 |= bus.done0 | bus.done1 | bus.busy | bus.ack0 | bus.ack1;
    end
    chk("rst_mid_no_done", saw1, 1'b0);
    chk("rst_mid_result", {bus.flag0, bus.result0}, '0);

    // Randomized traffic: a grant happens one cycle after any request seen while
    // the block has been quiet (no ack/done) for a cycle; ties alternate.
    do_reset();
    rq = '{default: 1'b0};
    e_ack = -1; e_done = -1; last_w = 1'b1;
    ea1 = '0; ea2 = '0; eop = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      chk("rnd_ack",  {bus.ack1, bus.ack0},   (e_ack  < 0) ? 64'd0 : 64'(1 << e_ack));
      chk("rnd_done", {bus.done1, bus.done0}, (e_done < 0) ? 64'd0 : 64'(1 << e_done));
      chk("rnd_busy", bus.busy, (e_ack >= 0) || (e_done >= 0));
      chk("rnd_alu_drive", {bus.alu_in1, bus.alu_in2, bus.alu_op},
          (e_ack >= 0) ? {ea1, ea2, eop} : AW'(0));
      if (e_done >= 0) begin
        er = alu_fn(ea1, ea2, eop);
        exp_res[e_done] = er[W-1:0]; exp_flag[e_done] = er[W];
      end
      chk("rnd_res0", res_of(1'b0), {exp_flag[0], exp_res[0]});
      chk("rnd_res1", res_of(1'b1), {exp_flag[1], exp_res[1]});
      for (int i = 0; i < 2; i++) begin
        if (e_ack == i) begin
          rq[i] = 1'b0;
          pa[i] = W'($urandom); pb[i] = W'($urandom); po[i] = OPW'($urandom);
        end else if (!rq[i]) begin
          if ($urandom_range(2) == 0) begin
            rq[i] = 1'b1;
            pa[i] = W'($urandom); pb[i] = W'($urandom); po[i] = OPW'($urandom);
          end
        end else if ($urandom_range(15) == 0) begin
          rq[i] = 1'b0;
        end
        drive_req(bit'(i), rq[i], pa[i], pb[i], po[i]);
      end
      n_ack = -1;
      if (e_ack < 0 && e_done < 0 && (rq[0] || rq[1])) begin
        w = (rq[0] && rq[1]) ? int'(!last_w) : int'(rq[1]);
        last_w = bit'(w);
        ea1 = pa[w]; ea2 = pb[w]; eop = po[w];
        n_ack = w;
      end
      e_done = e_ack;
      e_ack  = n_ack;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
